// File: rtl/reverse_pkg.sv
// rtl/reverse_pkg.sv - operation encoding and permutation function for reverse_pipe
//
// Purpose: shared types and the pure permutation function used by reverse_perm.
// Contents:
//   reverse_op_t  - 2-bit operation select (pass, bit reverse, byte swap, per-byte bit reverse)
//   BYTE_W        - byte width in bits
//   MAX_XLEN      - widest word reverse_apply can handle
//   reverse_apply - permutes the low xlen bits of dat according to op
package reverse_pkg;

  typedef enum logic [1:0] {
    OP_PASS  = 2'd0,
    OP_BREV  = 2'd1,
    OP_BSWAP = 2'd2,
    OP_BREV8 = 2'd3
  } reverse_op_t;

  localparam int BYTE_W   = 8;
  localparam int MAX_XLEN = 256;

  // Operates on a MAX_XLEN-wide carrier so one function serves every XLEN;
  // bits at and above xlen are returned as zero. The source index is computed
  // per destination bit, so no stream operator is needed.
  function automatic logic [MAX_XLEN-1:0] reverse_apply(
    input reverse_op_t           op,
    input logic [MAX_XLEN-1:0]   dat,
    input int                    xlen
  );
    logic [MAX_XLEN-1:0] res;
    logic [7:0]          src;
    int                  byte_idx;
    int                  bit_idx;
    res = '0;
    for (int i = 0; i < MAX_XLEN; i++) begin
      byte_idx = i / BYTE_W;
      bit_idx  = i % BYTE_W;
      case (op)
        OP_BREV:  src = 8'(xlen - 1 - i);
        OP_BSWAP: src = 8'((xlen / BYTE_W - 1 - byte_idx) * BYTE_W + bit_idx);
        OP_BREV8: src = 8'(byte_idx * BYTE_W + (BYTE_W - 1 - bit_idx));
        default:  src = 8'(i);
      endcase
      if (i < xlen) begin
        res[8'(i)] = dat[src];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/reverse_perm.sv
// rtl/reverse_perm.sv - combinational XLEN-bit permutation selected by operation
//
// Purpose: wraps reverse_apply for a fixed XLEN.
// Ports:
//   in_op   in   reverse_op_t  operation select
//   in_dat  in   XLEN          word to permute
//   out_dat out  XLEN          permuted word
module reverse_perm
  import reverse_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  reverse_op_t     in_op,
  input  logic [XLEN-1:0] in_dat,
  output logic [XLEN-1:0] out_dat
);

  logic [MAX_XLEN-1:0] dat_ext;
  logic [MAX_XLEN-1:0] res_ext;

  assign dat_ext = MAX_XLEN'(in_dat);
  assign res_ext = reverse_apply(in_op, dat_ext, XLEN);
  assign out_dat = res_ext[XLEN-1:0];

  // Upper carrier bits are always zero; they are deliberately left unused.
  generate
    if (XLEN < MAX_XLEN) begin : g_hi
      logic unused_hi;
      assign unused_hi = |res_ext[MAX_XLEN-1:XLEN];
    end
  endgenerate

endmodule

// File: rtl/reverse_pipe.sv
// rtl/reverse_pipe.sv - pipelined bit/byte permutation with valid/ready handshake
//
// Purpose: applies a per-word selectable permutation and registers the result.
// Optional macro REVERSE_PIPE_IN_EN adds an input register stage (latency 2);
// without it the block has a single output stage (latency 1).
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-high reset
//   in_vld   in   input word valid
//   in_rdy   out  block can accept an input word
//   in_op    in   2-bit operation (reverse_op_t encoding)
//   in_dat   in   XLEN input word
//   out_vld  out  output word valid
//   out_rdy  in   downstream accepts the output word
//   out_dat  out  XLEN permuted word
module reverse_pipe
  import reverse_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_vld,
  output logic            in_rdy,
  input  logic [1:0]      in_op,
  input  logic [XLEN-1:0] in_dat,
  output logic            out_vld,
  input  logic            out_rdy,
  output logic [XLEN-1:0] out_dat
);

  generate
    if (XLEN < BYTE_W || (XLEN % BYTE_W) != 0 || XLEN > MAX_XLEN) begin : g_bad_xlen
      $error("reverse_pipe: XLEN must be a multiple of 8 between 8 and %0d", MAX_XLEN);
    end
  endgenerate

  logic            out_vld_q;
  logic            out_vld_d;
  logic [XLEN-1:0] out_dat_q;
  logic [XLEN-1:0] out_dat_d;
  logic            out_stage_rdy;

  logic            perm_vld;
  reverse_op_t     perm_op;
  logic [XLEN-1:0] perm_dat;
  logic [XLEN-1:0] perm_res;

  // Output stage can take a word when empty or when its word leaves this cycle.
  assign out_stage_rdy = !out_vld_q || out_rdy;

`ifdef REVERSE_PIPE_IN_EN
  logic            stg_vld_q;
  logic            stg_vld_d;
  reverse_op_t     stg_op_q;
  reverse_op_t     stg_op_d;
  logic [XLEN-1:0] stg_dat_q;
  logic [XLEN-1:0] stg_dat_d;
  logic            stg_rdy;

  assign stg_rdy = !stg_vld_q || out_stage_rdy;

  always_comb begin
    stg_vld_d = stg_vld_q;
    stg_op_d  = stg_op_q;
    stg_dat_d = stg_dat_q;
    if (in_vld && stg_rdy) begin
      stg_vld_d = 1'b1;
      stg_op_d  = reverse_op_t'(in_op);
      stg_dat_d = in_dat;
    end else if (stg_vld_q && out_stage_rdy) begin
      stg_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_vld_q <= 1'b0;
      stg_op_q  <= OP_PASS;
      stg_dat_q <= '0;
    end else begin
      stg_vld_q <= stg_vld_d;
      stg_op_q  <= stg_op_d;
      stg_dat_q <= stg_dat_d;
    end
  end

  assign in_rdy   = stg_rdy;
  assign perm_vld = stg_vld_q;
  assign perm_op  = stg_op_q;
  assign perm_dat = stg_dat_q;
`else
  assign in_rdy   = out_stage_rdy;
  assign perm_vld = in_vld;
  assign perm_op  = reverse_op_t'(in_op);
  assign perm_dat = in_dat;
`endif

  reverse_perm #(
    .XLEN (XLEN)
  ) u_perm (
    .in_op   (perm_op),
    .in_dat  (perm_dat),
    .out_dat (perm_res)
  );

  // A new word wins over a departing one, so back-to-back traffic has no bubble.
  // out_dat only changes on a load, keeping it free of idle-input garbage.
  always_comb begin
    out_vld_d = out_vld_q;
    out_dat_d = out_dat_q;
    if (perm_vld && out_stage_rdy) begin
      out_vld_d = 1'b1;
      out_dat_d = perm_res;
    end else if (out_vld_q && out_rdy) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
    end else begin
      out_vld_q <= out_vld_d;
      out_dat_q <= out_dat_d;
    end
  end

  assign out_vld = out_vld_q;
  assign out_dat = out_dat_q;

endmodule

// File: tb/tb_reverse_pipe.sv
// tb/tb_reverse_pipe.sv - self-checking bench for reverse_pipe (XLEN=32 and XLEN=8)
module tb_reverse_pipe;
  import reverse_pkg::*;

`ifdef REVERSE_PIPE_IN_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_vld;
  logic        in_rdy;
  logic [1:0]  in_op;
  logic [31:0] in_dat;
  logic        out_vld;
  logic        out_rdy;
  logic [31:0] out_dat;

  logic        d8_in_vld;
  logic        d8_in_rdy;
  logic [1:0]  d8_in_op;
  logic [7:0]  d8_in_dat;
  logic        d8_out_vld;
  logic        d8_out_rdy;
  logic [7:0]  d8_out_dat;

  int          checks = 0;
  int          errors = 0;
  int          in_cnt = 0;
  int          out_cnt = 0;
  logic        in_acc = 1'b0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  reverse_pipe #(.XLEN(32)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (in_vld),
    .in_rdy  (in_rdy),
    .in_op   (in_op),
    .in_dat  (in_dat),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .out_dat (out_dat)
  );

  reverse_pipe #(.XLEN(8)) u_dut8 (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (d8_in_vld),
    .in_rdy  (d8_in_rdy),
    .in_op   (d8_in_op),
    .in_dat  (d8_in_dat),
    .out_vld (d8_out_vld),
    .out_rdy (d8_out_rdy),
    .out_dat (d8_out_dat)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_perm(input logic [1:0] op, input logic [31:0] d);
    logic [31:0] t;
    case (op)
      2'd1:    return {<<{d}};
      2'd2:    return {<<8{d}};
      2'd3: begin
        t = {<<{d}};
        return {<<8{t}};
      end
      default: return d;
    endcase
  endfunction

  task automatic set_in(input logic v, input logic [1:0] op, input logic [31:0] dat, input logic ordy);
    in_vld  = v;
    in_op   = op;
    in_dat  = dat;
    out_rdy = ordy;
  endtask

  // Called in the low clock phase after inputs are set; records the transfers
  // that the coming rising edge will perform, then waits for the next falling edge.
  task automatic tick();
    #1;
    if (out_vld && out_rdy) begin
      out_cnt++;
      check_eq("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check_eq("stream_data", out_dat, exp_q.pop_front());
    end
    in_acc = in_vld && in_rdy;
    if (in_acc) begin
      exp_q.push_back(ref_perm(in_op, in_dat));
      in_cnt++;
    end
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic        got_b;
    int          n_b;
    int          out_start;
    int          cyc;
    logic [1:0]  v8_op[4];
    logic [7:0]  v8_in[4];
    logic [7:0]  v8_exp[4];

    rst = 1'b1;
    set_in(1'b0, 2'd0, 32'd0, 1'b0);
    d8_in_vld = 1'b0; d8_in_op = 2'd0; d8_in_dat = 8'd0; d8_out_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_out_vld", 32'(out_vld), 32'd0);
    check_eq("reset_out_dat", out_dat, 32'd0);
    check_eq("reset_d8_out_vld", 32'(d8_out_vld), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("post_reset_in_rdy", 32'(in_rdy), 32'd1);
    check_eq("post_reset_d8_in_rdy", 32'(d8_in_rdy), 32'd1);

    // Single word, OP_BREV
    set_in(1'b1, OP_BREV, 32'h0000_0001, 1'b1);
    tick();
    repeat (LAT - 1) begin set_in(1'b0, 2'd0, 32'd0, 1'b1); tick(); end
    #1;
    check_eq("brev_vld", 32'(out_vld), 32'd1);
    check_eq("brev_dat", out_dat, 32'h8000_0000);
    set_in(1'b0, 2'd0, 32'd0, 1'b1);
    tick();
    #1;
    check_eq("brev_vld_drop", 32'(out_vld), 32'd0);

    // Back-to-back BSWAP then BREV8
    for (int c = 0; c <= LAT + 1; c++) begin
      set_in(c < 2, (c == 0) ? OP_BSWAP : OP_BREV8,
             (c == 0) ? 32'h1234_5678 : 32'h0102_0380, 1'b1);
      #1;
      if (c < 2) check_eq("b2b_in_rdy", 32'(in_rdy), 32'd1);
      if (c == LAT) begin
        check_eq("b2b_vld0", 32'(out_vld), 32'd1);
        check_eq("b2b_dat0", out_dat, 32'h7856_3412);
      end
      if (c == LAT + 1) begin
        check_eq("b2b_vld1", 32'(out_vld), 32'd1);
        check_eq("b2b_dat1", out_dat, 32'h8040_C001);
      end
      tick();
    end
    repeat (3) begin set_in(1'b0, 2'd0, 32'd0, 1'b1); tick(); end

    // Backpressure
    set_in(1'b1, OP_PASS, 32'hDEAD_BEEF, 1'b0);
    tick();
    got_b = 1'b0;
    n_b   = 0;
    for (int c = 0; c <= LAT + 3; c++) begin
      set_in(!got_b, OP_PASS, 32'h1122_3344, 1'b0);
      #1;
      if (c >= LAT - 1) begin
        check_eq("bp_in_rdy", 32'(in_rdy), 32'd0);
        check_eq("bp_out_vld", 32'(out_vld), 32'd1);
        check_eq("bp_out_dat", out_dat, 32'hDEAD_BEEF);
      end
      tick();
      if (in_acc) begin got_b = 1'b1; n_b++; end
    end
    out_start = out_cnt;
    set_in(!got_b, OP_PASS, 32'h1122_3344, 1'b1);
    #1;
    check_eq("bp_release_dat", out_dat, 32'hDEAD_BEEF);
    tick();
    if (in_acc) begin got_b = 1'b1; n_b++; end
    check_eq("bp_one_transfer", 32'(out_cnt - out_start), 32'd1);
    for (int c = 0; c < 8; c++) begin
      set_in(!got_b, OP_PASS, 32'h1122_3344, 1'b1);
      tick();
      if (in_acc) begin got_b = 1'b1; n_b++; end
    end
    check_eq("bp_pending_once", 32'(n_b), 32'd1);
    check_eq("bp_total_out", 32'(out_cnt - out_start), 32'd2);

    // Random stream of 1000 words
    cyc = 0;
    begin
      int start_in;
      start_in = in_cnt;
      while ((in_cnt - start_in) < 1000 && cyc < 20000) begin
        set_in($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom,
               $urandom_range(0, 3) != 0);
        tick();
        cyc++;
      end
    end
    check_eq("rand_no_timeout", 32'(cyc < 20000), 32'd1);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      set_in(1'b0, 2'($urandom_range(0, 3)), $urandom, 1'b1);
      tick();
      cyc++;
    end
    check_eq("rand_drained", 32'(exp_q.size()), 32'd0);
    check_eq("rand_count", 32'(out_cnt), 32'(in_cnt));

    // Reset while a word is held
    set_in(1'b1, OP_BREV8, 32'hA5A5_0F0F, 1'b0);
    tick();
    set_in(1'b1, OP_PASS, 32'h0000_0055, 1'b0);
    tick();
    #1;
    check_eq("mid_rst_pre_vld", 32'(out_vld), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_out_vld", 32'(out_vld), 32'd0);
    check_eq("mid_rst_out_dat", out_dat, 32'd0);
    exp_q.delete();
    set_in(1'b0, 2'd0, 32'd0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("mid_rst_in_rdy", 32'(in_rdy), 32'd1);
    check_eq("mid_rst_no_out", 32'(out_vld), 32'd0);
    tick();
    set_in(1'b1, OP_BREV, 32'h0000_00F0, 1'b1);
    tick();
    repeat (LAT - 1) begin set_in(1'b0, 2'd0, 32'd0, 1'b1); tick(); end
    #1;
    check_eq("post_rst_vld", 32'(out_vld), 32'd1);
    check_eq("post_rst_dat", out_dat, 32'h0F00_0000);
    repeat (2) begin set_in(1'b0, 2'd0, 32'd0, 1'b1); tick(); end
    check_eq("final_drained", 32'(exp_q.size()), 32'd0);

    // XLEN=8 instance
    v8_op[0] = OP_BSWAP; v8_in[0] = 8'hA5; v8_exp[0] = 8'hA5;
    v8_op[1] = OP_BREV;  v8_in[1] = 8'h01; v8_exp[1] = 8'h80;
    v8_op[2] = OP_BREV8; v8_in[2] = 8'h01; v8_exp[2] = 8'h80;
    v8_op[3] = OP_BREV;  v8_in[3] = 8'h3A; v8_exp[3] = 8'h5C;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      d8_in_vld = 1'b1; d8_in_op = v8_op[k]; d8_in_dat = v8_in[k]; d8_out_rdy = 1'b1;
      @(negedge clk);
      d8_in_vld = 1'b0;
      repeat (LAT - 1) @(negedge clk);
      #1;
      check_eq($sformatf("x8_vld_%0d", k), 32'(d8_out_vld), 32'd1);
      check_eq($sformatf("x8_dat_%0d", k), 32'(d8_out_dat), 32'(v8_exp[k]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reverse_pipe.md
Name: reverse_pipe

Overview:
- Parametrised, pipelined successor to the combinational bit-reverse function.
- Applies one of four selectable permutations to an XLEN-bit word: pass, full bit reverse, byte swap, or bit reverse within each byte.
- Uses a valid/ready handshake with a registered output at full throughput.
- Sits in the bit-manipulation datapath between operand fetch and writeback.

Parameters:
- XLEN, 32, data width in bits; must be a multiple of 8 and at least 8 (elaboration-time assertion).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- in_vld  input  1  input word valid.
- in_rdy  output  1  block can accept an input word.
- in_op  input  2  operation select, type reverse_op_t.
- in_dat  input  XLEN  input data.
- out_vld  output  1  output word valid.
- out_rdy  input  1  downstream accepts the output word.
- out_dat  output  XLEN  permuted data.

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous, active-high.
- Reset values: out_vld=0, out_dat=0. in_rdy=1 once reset is released.
- Operations (reverse_op_t):
  - OP_PASS=0: out = in.
  - OP_BREV=1: out[i] = in[XLEN-1-i].
  - OP_BSWAP=2: byte k moves to byte (XLEN/8-1-k).
  - OP_BREV8=3: bit j of each byte moves to bit 7-j of the same byte.
- Transfer rule: a transfer occurs on a rising clk edge where vld and rdy are both 1.
- Input transfer: the permuted word is registered into the output stage at that edge, so latency is 1 cycle (out_vld rises on the edge that accepts the input).
- in_rdy = !out_vld || out_rdy (combinational from out_rdy; no combinational path from in_vld).
- Throughput: one word per cycle with out_rdy held at 1.
- Output stage update:
  - Input transfer: load the new word, out_vld=1.
  - Output transfer with no input transfer: out_vld=0, out_dat holds its last value.
  - Simultaneous input and output transfer: load the new word, out_vld stays 1, no bubble.
- Backpressure: while out_vld=1 and out_rdy=0, out_dat and out_vld are stable and in_rdy=0.
- Operation sampling: in_op is sampled with the data; each word carries its own operation, and operations may change every cycle.
- XLEN=8: OP_BSWAP behaves as OP_PASS, and OP_BREV equals OP_BREV8.
- Reset mid-operation: any held word is discarded, out_vld drops immediately (asynchronously), and no output transfer is reported afterwards.
- No X propagation: in_dat/in_op are ignored when in_vld=0, and out_dat is only updated on an input transfer.

Optional Feature:
- Macro: REVERSE_PIPE_IN_EN.
- Defined:
  - Adds an input register stage holding {op, dat, vld} before the permutation, giving latency 2.
  - Each stage follows the same ready rule: stage_rdy = !stage_vld || next_rdy.
  - Full throughput is kept; reset clears both stage valids.
- Undefined: single stage, latency 1, as above.

Decomposition:
- Package reverse_pkg:
  - enum reverse_op_t (2-bit, values above).
  - localparam BYTE_W=8.
  - Pure function reverse_apply(op, dat) built from loops, so no stream operator is needed.
- Sub-module reverse_perm:
  - Combinational XLEN-parametrised permutation (in_op, in_dat -> out_dat) wrapping reverse_apply.
  - Instantiated once, between the optional input stage and the output register.

Test Plan:
- XLEN=32, OP_BREV, in_dat=0x0000_0001, out_rdy=1 -> next cycle out_vld=1, out_dat=0x8000_0000; with in_vld then 0, out_vld=0 one cycle later.
- OP_BSWAP 0x1234_5678 then OP_BREV8 0x0102_0380 on back-to-back cycles, out_rdy=1 -> outputs 0x7856_3412 then 0x8040_C001 on consecutive cycles, in_rdy constantly 1.
- Backpressure: load 0xDEAD_BEEF with OP_PASS, hold out_rdy=0 for 5 cycles while in_vld=1 -> in_rdy=0, out_dat stable at 0xDEAD_BEEF; raise out_rdy -> exactly one output transfer, then the pending input is accepted with no loss or duplication.
- Random stream of 1000 words, random in_vld/out_rdy -> output sequence equals the reference-model sequence; count in == count out.
- Assert rst mid-stream with out_vld=1 -> out_vld=0 immediately (before the next edge), out_dat=0; after release in_rdy=1 and the first new word emerges correctly.
- XLEN=8 build: OP_BSWAP 0xA5 -> 0xA5; OP_BREV 0x01 -> 0x80; OP_BREV8 0x01 -> 0x80. With REVERSE_PIPE_IN_EN defined, repeat the back-to-back test -> identical data with 2-cycle latency.
